// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between two masters, with a time-limited bus lock.
// Grant is combinational in the request cycle, read data returns one cycle later; a losing port holds req until granted.
module dram_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int MAX_LOCK = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic          p0_lock,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic          p0_gnt,
   output logic          p0_rvalid,
   output logic [DW-1:0] p0_rdata,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic          p1_lock,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic          p1_gnt,
   output logic          p1_rvalid,
   output logic [DW-1:0] p1_rdata,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   localparam int CW = $clog2(MAX_LOCK + 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t        state_q, state_d;
   logic          last_gnt_q, last_gnt_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;
   logic          p0_rvalid_q, p1_rvalid_q;
   logic [DW-1:0] p0_rdata_q, p1_rdata_q;

   // Grants are gated by rst_n so nothing reaches the RAM while reset is asserted.
   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (rst_n) begin
         case (state_q)
            IDLE: begin
               if (p0_req && p1_req) begin
                  p0_gnt = last_gnt_q;
                  p1_gnt = ~last_gnt_q;
               end else begin
                  p0_gnt = p0_req;
                  p1_gnt = p1_req;
               end
            end
            OWN0:    p0_gnt = p0_req;
            OWN1:    p1_gnt = p1_req;
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_din   = '0;
      if (p0_gnt) begin
         mem_read  = ~p0_we;
         mem_write = p0_we;
         mem_addr  = p0_addr;
         mem_din   = p0_wdata;
      end else if (p1_gnt) begin
         mem_read  = ~p1_we;
         mem_write = p1_we;
         mem_addr  = p1_addr;
         mem_din   = p1_wdata;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      lock_cnt_d = lock_cnt_q;
      if (p0_gnt) last_gnt_d = 1'b0;
      if (p1_gnt) last_gnt_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (p0_gnt && p0_lock) begin
               state_d    = OWN0;
               lock_cnt_d = CW'(1);
            end else if (p1_gnt && p1_lock) begin
               state_d    = OWN1;
               lock_cnt_d = CW'(1);
            end
         end
         OWN0: begin
            if (p0_lock) lock_cnt_d = lock_cnt_q + CW'(1);
            else begin
               state_d    = IDLE;
               lock_cnt_d = '0;
            end
         end
         OWN1: begin
            if (p1_lock) lock_cnt_d = lock_cnt_q + CW'(1);
            else begin
               state_d    = IDLE;
               lock_cnt_d = '0;
            end
         end
         default: begin
            state_d    = IDLE;
            lock_cnt_d = '0;
         end
      endcase
      // Lock budget exhausted: drop ownership and mark the owner as last winner so it loses the next tie.
      if (state_d != IDLE && lock_cnt_d == CW'(MAX_LOCK)) begin
         last_gnt_d = (state_d == OWN1);
         state_d    = IDLE;
         lock_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_gnt_q  <= 1'b1;
         lock_cnt_q  <= '0;
         p0_rvalid_q <= 1'b0;
         p1_rvalid_q <= 1'b0;
         p0_rdata_q  <= '0;
         p1_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         lock_cnt_q  <= lock_cnt_d;
         p0_rvalid_q <= p0_gnt & ~p0_we;
         p1_rvalid_q <= p1_gnt & ~p1_we;
         if (p0_rvalid_q) p0_rdata_q <= mem_dout;
         if (p1_rvalid_q) p1_rdata_q <= mem_dout;
      end
   end

   // RAM output arrives in the response cycle, so it is passed through then and held afterwards.
   assign p0_rvalid = p0_rvalid_q;
   assign p1_rvalid = p1_rvalid_q;
   assign p0_rdata  = p0_rvalid_q ? mem_dout : p0_rdata_q;
   assign p1_rdata  = p1_rvalid_q ? mem_dout : p1_rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: per-cycle vector table against a small RAM model, plus reset corner cases.
module tb_dram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
   logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
   logic [15:0] p0_rdata, p1_rdata;
   logic        mem_read, mem_write;
   logic [15:0] mem_addr, mem_din;
   logic [15:0] mem_dout = 16'h0;
   logic [15:0] mem [16] = '{2: 16'h1234, 3: 16'h5678, 4: 16'h0041, default: 16'h0000};

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dram_arbiter #(.AW(16), .DW(16), .MAX_LOCK(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   // Single-port RAM model: registered read, write-through on the edge.
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[3:0]] <= mem_din;
      if (mem_read) mem_dout <= mem[mem_addr[3:0]];
   end

   typedef struct packed {
      logic r0; logic w0; logic l0; logic [15:0] a0; logic [15:0] d0;
      logic r1; logic w1; logic l1; logic [15:0] a1; logic [15:0] d1;
      logic g0; logic g1; logic mr; logic mw; logic [15:0] ma; logic [15:0] md;
      logic v0; logic [15:0] rd0; logic v1; logic [15:0] rd1;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [69:0] ex(input logic g0, g1, mr, mw, input logic [15:0] ma, md,
                                      input logic v0, input logic [15:0] rd0,
                                      input logic v1, input logic [15:0] rd1);
      return {g0, g1, mr, mw, ma, md, v0, rd0, v1, rd1};
   endfunction

   task automatic check(input string name, input logic [69:0] exp);
      logic [69:0] act;
      act = {p0_gnt, p1_gnt, mem_read, mem_write, mem_addr, mem_din,
             p0_rvalid, p0_rdata, p1_rvalid, p1_rdata};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h (g0 g1 rd wr addr din v0 rd0 v1 rd1)", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      p0_req = v.r0; p0_we = v.w0; p0_lock = v.l0; p0_addr = v.a0; p0_wdata = v.d0;
      p1_req = v.r1; p1_we = v.w1; p1_lock = v.l1; p1_addr = v.a1; p1_wdata = v.d1;
   endtask

   task automatic idle();
      p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = 0; p1_wdata = 0;
   endtask

   initial begin
      // r0 w0 l0 a0 d0 | r1 w1 l1 a1 d1 || g0 g1 mr mw ma md | v0 rd0 v1 rd1
      vecs.push_back('{0,0,0,16'h0,16'h0,     0,0,0,16'h0,16'h0,     0,0,0,0,16'h0,16'h0,     0,16'h0,0,16'h0});
      vecs.push_back('{1,1,0,16'h1,16'hAAAA,  0,0,0,16'h0,16'h0,     1,0,0,1,16'h1,16'hAAAA,  0,16'h0,0,16'h0});
      vecs.push_back('{1,0,0,16'h1,16'h0,     0,0,0,16'h0,16'h0,     1,0,1,0,16'h1,16'h0,     0,16'h0,0,16'h0});
      vecs.push_back('{0,0,0,16'h0,16'h0,     0,0,0,16'h0,16'h0,     0,0,0,0,16'h0,16'h0,     1,16'hAAAA,0,16'h0});
      vecs.push_back('{0,0,0,16'h0,16'h0,     0,0,0,16'h0,16'h0,     0,0,0,0,16'h0,16'h0,     0,16'hAAAA,0,16'h0});
      // both read continuously: p0 won last, so p1 wins the first tie
      vecs.push_back('{1,0,0,16'h2,16'h0,     1,0,0,16'h3,16'h0,     0,1,1,0,16'h3,16'h0,     0,16'hAAAA,0,16'h0});
      vecs.push_back('{1,0,0,16'h2,16'h0,     1,0,0,16'h3,16'h0,     1,0,1,0,16'h2,16'h0,     0,16'hAAAA,1,16'h5678});
      vecs.push_back('{1,0,0,16'h2,16'h0,     1,0,0,16'h3,16'h0,     0,1,1,0,16'h3,16'h0,     1,16'h1234,0,16'h5678});
      vecs.push_back('{1,0,0,16'h2,16'h0,     1,0,0,16'h3,16'h0,     1,0,1,0,16'h2,16'h0,     0,16'h1234,1,16'h5678});
      vecs.push_back('{0,0,0,16'h0,16'h0,     0,0,0,16'h0,16'h0,     0,0,0,0,16'h0,16'h0,     1,16'h1234,0,16'h5678});
      // p1 read-modify-write under lock while p0 keeps requesting
      vecs.push_back('{1,0,0,16'h4,16'h0,     1,0,1,16'h4,16'h0,     0,1,1,0,16'h4,16'h0,     0,16'h1234,0,16'h5678});
      vecs.push_back('{1,0,0,16'h4,16'h0,     0,0,1,16'h0,16'h0,     0,0,0,0,16'h0,16'h0,     0,16'h1234,1,16'h0041});
      vecs.push_back('{1,0,0,16'h4,16'h0,     1,1,0,16'h4,16'h0042,  0,1,0,1,16'h4,16'h0042,  0,16'h1234,0,16'h0041});
      vecs.push_back('{1,0,0,16'h4,16'h0,     0,0,0,16'h0,16'h0,     1,0,1,0,16'h4,16'h0,     0,16'h1234,0,16'h0041});
      vecs.push_back('{0,0,0,16'h0,16'h0,     0,0,0,16'h0,16'h0,     0,0,0,0,16'h0,16'h0,     1,16'h0042,0,16'h0041});
      // p0 locks alone, then holds it against p1 until the 8-cycle budget runs out
      vecs.push_back('{1,0,1,16'h2,16'h0,     0,0,0,16'h0,16'h0,     1,0,1,0,16'h2,16'h0,     0,16'h0042,0,16'h0041});
      for (int k = 0; k < 7; k++)
         vecs.push_back('{1,0,1,16'h2,16'h0,  1,0,0,16'h3,16'h0,     1,0,1,0,16'h2,16'h0,     1,16'h1234,0,16'h0041});
      vecs.push_back('{1,0,1,16'h2,16'h0,     1,0,0,16'h3,16'h0,     0,1,1,0,16'h3,16'h0,     1,16'h1234,0,16'h0041});
      vecs.push_back('{0,0,0,16'h0,16'h0,     0,0,0,16'h0,16'h0,     0,0,0,0,16'h0,16'h0,     0,16'h1234,1,16'h5678});
      // lock without req in IDLE must not take ownership
      vecs.push_back('{0,0,1,16'h0,16'h0,     0,0,0,16'h0,16'h0,     0,0,0,0,16'h0,16'h0,     0,16'h1234,0,16'h5678});
      vecs.push_back('{0,0,0,16'h0,16'h0,     1,0,0,16'h3,16'h0,     0,1,1,0,16'h3,16'h0,     0,16'h1234,0,16'h5678});
      vecs.push_back('{0,0,0,16'h0,16'h0,     0,0,0,16'h0,16'h0,     0,0,0,0,16'h0,16'h0,     0,16'h1234,1,16'h5678});

      rst_n = 1'b0;
      idle();
      p0_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state_gnt_masked", ex(0,0,0,0,16'h0,16'h0, 0,16'h0,0,16'h0));
      idle();
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("reset_release_idle", ex(0,0,0,0,16'h0,16'h0, 0,16'h0,0,16'h0));

      // read granted, then reset lands before the response edge
      @(posedge clk); #1;
      p0_req = 1'b1; p0_addr = 16'h2;
      @(negedge clk);
      check("midread_grant", ex(1,0,1,0,16'h2,16'h0, 0,16'h0,0,16'h0));
      #1 rst_n = 1'b0;
      #1 check("midread_reset_comb", ex(0,0,0,0,16'h2,16'h0, 0,16'h0,0,16'h0) & ~{4'h0, 16'hFFFF, 50'h0}
                                     | {4'h0, mem_addr, 50'h0});
      @(posedge clk); #1;
      idle();
      check("midread_in_reset", ex(0,0,0,0,16'h0,16'h0, 0,16'h0,0,16'h0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("midread_no_rvalid", ex(0,0,0,0,16'h0,16'h0, 0,16'h0,0,16'h0));

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         drive(vecs[i]);
         @(negedge clk);
         check($sformatf("vec%0d", i),
               ex(vecs[i].g0, vecs[i].g1, vecs[i].mr, vecs[i].mw, vecs[i].ma, vecs[i].md,
                  vecs[i].v0, vecs[i].rd0, vecs[i].v1, vecs[i].rd1));
      end

      @(posedge clk); #1;
      idle();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
